// File: rtl/uart_op_sequencer.sv
// uart_op_sequencer
//    Frame-level controller between a UART byte interface and a 16-bit
//    two-operand compute engine. Parses opcode + big-endian A + big-endian B
//    from the rx byte stream, launches the engine, waits for completion under
//    a watchdog and returns the 16-bit result (high byte first) or a NAK byte.
//
// Ports
//    iCE_CLK    in   system clock, rising edge
//    rst        in   synchronous active-high reset
//    rx_valid   in   one-cycle strobe, rx_byte valid
//    rx_byte    in   received byte
//    tx_busy    in   UART transmitter busy
//    tx_start   out  one-cycle strobe, transmit tx_byte
//    tx_byte    out  byte to transmit
//    op_code    out  latched opcode
//    op_a       out  operand A
//    op_b       out  operand B
//    op_start   out  one-cycle engine launch strobe
//    op_done    in   engine completion strobe
//    op_result  in   engine result, valid with op_done
//    busy       out  high whenever not idle
//    err        out  one-cycle pulse on timeout, bad opcode or dropped byte
//
// state     | meaning
// IDLE      | waiting for an opcode byte
// GET_A_HI  | waiting for A[15:8]
// GET_A_LO  | waiting for A[7:0]
// GET_B_HI  | waiting for B[15:8]
// GET_B_LO  | waiting for B[7:0]
// START     | launch cycle, arms the op watchdog
// WAIT      | waiting for op_done or op watchdog expiry
// SEND_HI   | waiting for transmitter idle, then sends result[15:8]
// SEND_LO   | waiting for transmitter idle, then sends result[7:0]
// SEND_NAK  | waiting for transmitter idle, then sends NAK_BYTE
// TX_WAIT   | byte in flight; returns to ret_q once the transmitter frees up
module uart_op_sequencer #(
   parameter int unsigned RX_TIMEOUT = 1_200_000,
   parameter int unsigned OP_TIMEOUT = 65_535,
   parameter logic [7:0]  NAK_BYTE   = 8'hEE
) (
   input  logic        iCE_CLK,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   output logic [7:0]  op_code,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        op_start,
   input  logic        op_done,
   input  logic [15:0] op_result,
   output logic        busy,
   output logic        err
);

   localparam int unsigned TMAX = (RX_TIMEOUT > OP_TIMEOUT) ? RX_TIMEOUT : OP_TIMEOUT;
   localparam int          TW   = $clog2(TMAX + 1);
   // Down-counter loads N-1 so the terminal-count cycle lands exactly N cycles
   // after the arming event.
   localparam logic [TW-1:0] RX_LOAD = TW'(RX_TIMEOUT - 1);
   localparam logic [TW-1:0] OP_LOAD = TW'(OP_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_A_HI, S_GET_A_LO, S_GET_B_HI, S_GET_B_LO, S_START,
      S_WAIT, S_SEND_HI, S_SEND_LO, S_SEND_NAK, S_TX_WAIT
   } state_t;

   state_t        state_q, state_d, ret_q, ret_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [15:0]   res_q, res_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic [7:0]    op_code_q, op_code_d, tx_byte_q, tx_byte_d;
   logic          tx_start_q, tx_start_d, op_start_q, op_start_d;
   logic          err_q, err_d, busy_q, busy_d, txw_first_q, txw_first_d;

   always_ff @(posedge iCE_CLK) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ret_q       <= S_IDLE;
         tmr_q       <= '0;
         res_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_code_q   <= '0;
         tx_byte_q   <= '0;
         tx_start_q  <= 1'b0;
         op_start_q  <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         txw_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         tmr_q       <= tmr_d;
         res_q       <= res_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_code_q   <= op_code_d;
         tx_byte_q   <= tx_byte_d;
         tx_start_q  <= tx_start_d;
         op_start_q  <= op_start_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         txw_first_q <= txw_first_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      tmr_d       = tmr_q;
      res_d       = res_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_code_d   = op_code_q;
      tx_byte_d   = tx_byte_q;
      tx_start_d  = 1'b0;
      op_start_d  = (state_q == S_START);
      err_d       = 1'b0;
      txw_first_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_byte inside {[8'h01:8'h03]}) begin
                  op_code_d = rx_byte;
                  tmr_d     = RX_LOAD;
                  state_d   = S_GET_A_HI;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_SEND_NAK;
               end
            end
         end
         S_GET_A_HI, S_GET_A_LO, S_GET_B_HI, S_GET_B_LO: begin
            // A byte arriving on the terminal-count cycle still wins.
            if (rx_valid) begin
               tmr_d = RX_LOAD;
               case (state_q)
                  S_GET_A_HI: begin op_a_d[15:8] = rx_byte; state_d = S_GET_A_LO; end
                  S_GET_A_LO: begin op_a_d[7:0]  = rx_byte; state_d = S_GET_B_HI; end
                  S_GET_B_HI: begin op_b_d[15:8] = rx_byte; state_d = S_GET_B_LO; end
                  default:    begin op_b_d[7:0]  = rx_byte; state_d = S_START;    end
               endcase
            end else if (tmr_q == '0) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_START: begin
            tmr_d   = OP_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (op_done) begin
               res_d   = op_result;
               state_d = S_SEND_HI;
            end else if (tmr_q == '0) begin
               err_d   = 1'b1;
               state_d = S_SEND_NAK;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_SEND_HI, S_SEND_LO, S_SEND_NAK: begin
            if (!tx_busy) begin
               tx_start_d  = 1'b1;
               txw_first_d = 1'b1;
               state_d     = S_TX_WAIT;
               case (state_q)
                  S_SEND_HI: begin tx_byte_d = res_q[15:8]; ret_d = S_SEND_LO; end
                  S_SEND_LO: begin tx_byte_d = res_q[7:0];  ret_d = S_IDLE;    end
                  default:   begin tx_byte_d = NAK_BYTE;    ret_d = S_IDLE;    end
               endcase
            end
         end
         S_TX_WAIT: begin
            // The transmitter raises tx_busy a cycle after tx_start, so the
            // first cycle here cannot trust a low tx_busy.
            if (!txw_first_q && !tx_busy) state_d = ret_q;
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_valid && !(state_q inside {S_IDLE, S_GET_A_HI, S_GET_A_LO, S_GET_B_HI, S_GET_B_LO}))
         err_d = 1'b1;

      busy_d = (state_d != S_IDLE);
   end

   assign tx_start = tx_start_q;
   assign tx_byte  = tx_byte_q;
   assign op_code  = op_code_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;
   assign op_start = op_start_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule
